// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cpu memory bus: operation codes, MMIO addresses, responder states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_bus_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [7:0] IO_OUT_ADDR_DFLT = 8'hFF;
    localparam logic [7:0] IO_IN_ADDR_DFLT  = 8'hFE;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Plain 2**ADDR_W x DATA_W storage with one synchronous write port and one asynchronous read port.
// Latency: writes land on the clock edge; reads are combinational.
// Backpressure: none; no reset, so contents survive a responder reset.
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Single write port; deliberately unreset storage.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: boot-loads RAM from a byte stream, then serves CPU reads/writes plus two MMIO bytes.
// Latency: CPU reads are zero-latency (combinational); writes, io_out and its strobe update on the next edge.
// Backpressure: load_ready is high for the whole LOAD phase and low in RUN; the CPU is held via cpu_run.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] IO_OUT_ADDR = ADDR_W'(IO_OUT_ADDR_DFLT),
    parameter logic [ADDR_W-1:0] IO_IN_ADDR  = ADDR_W'(IO_IN_ADDR_DFLT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memory_operation,
    input  logic [ADDR_W-1:0] memory_address,
    input  logic [DATA_W-1:0] to_memory,
    output logic [DATA_W-1:0] from_memory,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_run,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_strobe,
    input  logic [DATA_W-1:0] io_in
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic [DATA_W-1:0] io_out_q, io_out_d;
    logic              strobe_q, strobe_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic load_fire;
    logic cpu_wr;
    logic hit_io_out;
    logic hit_io_in;

    assign load_fire  = (state_q == ST_LOAD) && load_valid;
    assign cpu_wr     = (state_q == ST_RUN) && (memory_operation == MEM_WRITE);
    assign hit_io_out = (memory_address == IO_OUT_ADDR);
    assign hit_io_in  = (memory_address == IO_IN_ADDR);

    // State register; async reset drops cpu_run immediately so the CPU is held during reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave LOAD after the marked last byte or after filling the top address; RUN is terminal.
    always_comb begin
        state_d = state_q;
        if (load_fire && (load_last || (load_ptr_q == '1))) begin
            state_d = ST_RUN;
        end
    end

    // Handshake outputs are pure decodes of the state.
    always_comb begin
        load_ready = (state_q == ST_LOAD);
        cpu_run    = (state_q == ST_RUN);
    end

    // Loader owns the write port in LOAD; CPU owns it in RUN, except for the MMIO addresses.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = memory_address;
        mem_wdata = to_memory;
        if (load_fire) begin
            mem_we    = 1'b1;
            mem_waddr = load_ptr_q;
            mem_wdata = load_data;
        end else if (cpu_wr && !hit_io_out && !hit_io_in) begin
            mem_we    = 1'b1;
        end
    end

    // Load pointer and MMIO output latch next-state; strobe is high only for the cycle after a write.
    always_comb begin
        load_ptr_d = load_ptr_q;
        io_out_d   = io_out_q;
        strobe_d   = 1'b0;
        if (load_fire) begin
            load_ptr_d = load_ptr_q + 1'b1;
        end
        if (cpu_wr && hit_io_out) begin
            io_out_d = to_memory;
            strobe_d = 1'b1;
        end
    end

    // Datapath registers; load pointer restarts at 0 on every reset so partial images reload from the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_ptr_q <= '0;
            io_out_q   <= '0;
            strobe_q   <= 1'b0;
        end else begin
            load_ptr_q <= load_ptr_d;
            io_out_q   <= io_out_d;
            strobe_q   <= strobe_d;
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (memory_address),
        .rdata_o (mem_rdata)
    );

    assign io_out        = io_out_q;
    assign io_out_strobe = strobe_q;
    assign from_memory   = hit_io_in  ? io_in    :
                           hit_io_out ? io_out_q : mem_rdata;

endmodule
